// File: rtl/lut_seq_pkg.sv
// Shared types and helpers for the LUT-layer sequencers: FSM state encoding,
// default fan-in, and truth-table lookup.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FANIN_DEF = 8;
  localparam int TBL_W_DEF = 2 ** FANIN_DEF;

  // Tables narrower than the default are zero-extended by the caller.
  // FANIN must not exceed FANIN_DEF.
  function automatic logic table_bit(input logic [TBL_W_DEF-1:0] tbl,
                                     input logic [FANIN_DEF-1:0] addr);
    return tbl[addr];
  endfunction

endpackage

// File: rtl/lut_cfg_mem.sv
// Per-neuron configuration store: register array with one synchronous write
// port and one combinational read port. Contents survive reset.
module lut_cfg_mem
  import lut_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = FANIN_DEF * 8 + TBL_W_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lut_layer_seq.sv
// Time-multiplexed LogicNets layer: one shared truth-table lookup per cycle
// walks every neuron of the layer over a latched activation vector.
module lut_layer_seq
  import lut_seq_pkg::*;
#(
  parameter int IN_BITS     = 256,
  parameter int NUM_NEURONS = 64,
  parameter int FANIN       = FANIN_DEF,
  parameter int IDX_W       = $clog2(IN_BITS),
  parameter int NID_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [NID_W-1:0]       cfg_nid,
  input  logic [FANIN*IDX_W-1:0] cfg_map,
  input  logic [(2**FANIN)-1:0]  cfg_table,
  output logic                   cfg_ready,
  input  logic                   s_valid,
  input  logic [IN_BITS-1:0]     s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [NUM_NEURONS-1:0] m_data,
  input  logic                   m_ready,
  output logic                   busy
);

  localparam int MAP_W = FANIN * IDX_W;
  localparam int TBL_W = 2 ** FANIN;
  localparam int CNT_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [CNT_W-1:0] LAST_NID = CNT_W'(NUM_NEURONS - 1);

  state_t                   r_state;
  state_t                   w_nextState;
  logic [IN_BITS-1:0]       r_vec;
  logic [CNT_W-1:0]         r_cnt;
  logic [NUM_NEURONS-1:0]   r_mData;
  logic                     w_sAcc;
  logic                     w_cfgWr;
  logic [MAP_W+TBL_W-1:0]   w_rdWord;
  logic [MAP_W-1:0]         w_rdMap;
  logic [TBL_W-1:0]         w_rdTable;
  logic [FANIN-1:0]         w_addr;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_bit;

  assign w_sAcc  = s_valid && s_ready;
  assign w_cfgWr = cfg_we && cfg_ready && (int'(cfg_nid) < NUM_NEURONS);

  lut_cfg_mem #(
    .DEPTH (NUM_NEURONS),
    .WIDTH (MAP_W + TBL_W),
    .AW    (CNT_W)
  ) u_cfgMem (
    .clk     (clk),
    .i_we    (w_cfgWr),
    .i_waddr (cfg_nid[CNT_W-1:0]),
    .i_wdata ({cfg_map, cfg_table}),
    .i_raddr (r_cnt),
    .o_rdata (w_rdWord)
  );

  assign w_rdMap   = w_rdWord[MAP_W+TBL_W-1:TBL_W];
  assign w_rdTable = w_rdWord[TBL_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_sAcc) w_nextState = RUN;
      RUN:     if (r_cnt == LAST_NID) w_nextState = DONE;
      DONE:    if (m_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Nothing is accepted while reset is held, even though the state already reads IDLE.
  always_comb begin
    s_ready   = 1'b0;
    cfg_ready = 1'b0;
    m_valid   = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        s_ready   = rst;
        cfg_ready = rst;
        busy      = 1'b0;
      end
      DONE:    m_valid = 1'b1;
      default: ;
    endcase
  end

  // Out-of-range fan-in indices contribute a 0 address bit.
  always_comb begin
    w_addr = '0;
    w_idx  = '0;
    for (int k = 0; k < FANIN; k++) begin
      w_idx = w_rdMap[k*IDX_W +: IDX_W];
      if (int'(w_idx) < IN_BITS) begin
        w_addr[k] = r_vec[w_idx];
      end
    end
  end

  assign w_bit = table_bit(TBL_W_DEF'(w_rdTable), FANIN_DEF'(w_addr));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vec   <= '0;
      r_cnt   <= '0;
      r_mData <= '0;
    end else begin
      if (r_state == IDLE && w_sAcc) begin
        r_vec <= s_data;
        r_cnt <= '0;
      end
      if (r_state == RUN) begin
        r_mData[r_cnt] <= w_bit;
        if (r_cnt != LAST_NID) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign m_data = r_mData;

endmodule

// File: tb/tb_lut_layer_seq.sv
// Randomised self-checking bench for lut_layer_seq: a neuron-level reference model
// follows accepted config writes and predicts every result vector.
module tb_lut_layer_seq;

  localparam int IN_BITS = 256;
  localparam int NN      = 64;
  localparam int FANIN   = 8;
  localparam int IDX_W   = 8;
  localparam int NID_W   = 7;
  localparam int LAT     = NN + 1;
  localparam int BOUND   = 300;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_we = 1'b0;
  logic [NID_W-1:0]   cfg_nid = '0;
  logic [63:0]        cfg_map = '0;
  logic [255:0]       cfg_table = '0;
  logic               cfg_ready;
  logic               s_valid = 1'b0;
  logic [IN_BITS-1:0] s_data = '0;
  logic               s_ready;
  logic               m_valid;
  logic [NN-1:0]      m_data;
  logic               m_ready = 1'b0;
  logic               busy;

  lut_layer_seq #(
    .IN_BITS(IN_BITS), .NUM_NEURONS(NN), .FANIN(FANIN), .IDX_W(IDX_W), .NID_W(NID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_nid(cfg_nid), .cfg_map(cfg_map), .cfg_table(cfg_table),
    .cfg_ready(cfg_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int            nChecks = 0;
  int            nFails = 0;
  int            mMap [NN][FANIN];
  logic [255:0]  mTbl [NN];
  logic [NN-1:0] expQ [$];
  int            cyc = 0;
  int            acceptCyc = -1;
  logic          prevMValid = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NN-1:0] modelEval(input logic [IN_BITS-1:0] vec);
    logic [NN-1:0] res;
    int a;
    res = '0;
    for (int n = 0; n < NN; n++) begin
      a = 0;
      for (int k = 0; k < FANIN; k++) begin
        if (mMap[n][k] < IN_BITS && vec[mMap[n][k]]) a += (1 << k);
      end
      res[n] = mTbl[n][a];
    end
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model follows the ports: config writes land before a same-cycle vector accept.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      expQ.delete();
      acceptCyc  = -1;
      prevMValid = 1'b0;
    end else begin
      checkOutput("s_ready_vs_busy", 256'(s_ready), 256'(!busy));
      if (m_valid) begin
        if (!prevMValid) checkOutput("latency", 256'(cyc - acceptCyc), 256'(LAT));
        if (expQ.size() == 0) checkOutput("unexpected_result", 256'(m_valid), 256'(0));
        else begin
          checkOutput("m_data_model", 256'(m_data), 256'(expQ[0]));
          if (m_ready) void'(expQ.pop_front());
        end
      end
      prevMValid = m_valid;
      if (cfg_we && cfg_ready && int'(cfg_nid) < NN) begin
        for (int k = 0; k < FANIN; k++) mMap[int'(cfg_nid)][k] = int'(cfg_map[k*IDX_W +: IDX_W]);
        mTbl[int'(cfg_nid)] = cfg_table;
      end
      if (s_valid && s_ready) begin
        expQ.push_back(modelEval(s_data));
        acceptCyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configNeuron(input int nid, input logic [63:0] map, input logic [255:0] tbl);
    cfg_we = 1'b1; cfg_nid = NID_W'(nid); cfg_map = map; cfg_table = tbl;
    for (int i = 0; i < BOUND && !cfg_ready; i++) tick();
    if (!cfg_ready) checkOutput("cfg_timeout", 256'(cfg_ready), 256'(1));
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [IN_BITS-1:0] vec);
    s_valid = 1'b1; s_data = vec;
    for (int i = 0; i < BOUND && !s_ready; i++) tick();
    if (!s_ready) checkOutput("accept_timeout", 256'(s_ready), 256'(1));
    tick();
    s_valid = 1'b0;
  endtask

  task automatic waitValid();
    for (int i = 0; i < BOUND && !m_valid; i++) tick();
    if (!m_valid) checkOutput("result_timeout", 256'(m_valid), 256'(1));
  endtask

  task automatic waitResult(output logic [NN-1:0] res);
    m_ready = 1'b1;
    waitValid();
    res = m_data;
    tick();
  endtask

  initial begin
    logic [255:0]  idTbl;
    logic [255:0]  majTbl;
    logic [NN-1:0] res;
    logic [NN-1:0] held;
    logic [NN-1:0] pin;

    idTbl = {128{2'b10}};
    for (int a = 0; a < 256; a++) majTbl[a] = ($countones(8'(a)) >= 5);

    // Reset held with a pending vector
    rst = 1'b0; s_valid = 1'b1; s_data = rand256();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_m_valid", 256'(m_valid), 256'(0));
      checkOutput("rst_m_data", 256'(m_data), 256'(0));
      checkOutput("rst_s_ready", 256'(s_ready), 256'(0));
    end
    rst = 1'b1; s_valid = 1'b0;
    tick();
    checkOutput("post_rst_s_ready", 256'(s_ready), 256'(1));
    checkOutput("post_rst_busy", 256'(busy), 256'(0));

    // Identity neurons
    for (int n = 0; n < NN; n++) configNeuron(n, 64'(n), idTbl);
    applyStimulus({rand256() >> 64, 64'h0123_4567_89AB_CDEF} );
    waitResult(res);
    checkOutput("identity", 256'(res), 256'(64'h0123_4567_89AB_CDEF));

    // Majority-of-8 on neuron 5
    configNeuron(5, 64'h0706_0504_0302_0100, majTbl);
    pin = modelEval(256'h1F);
    checkOutput("model_pin_1F", 256'(pin[5]), 256'(1));
    pin = modelEval(256'h0F);
    checkOutput("model_pin_0F", 256'(pin[5]), 256'(0));
    applyStimulus({rand256() >> 8, 8'h0F});
    waitResult(res);
    checkOutput("maj_0F", 256'(res[5]), 256'(0));
    applyStimulus({rand256() >> 8, 8'h1F});
    waitResult(res);
    checkOutput("maj_1F", 256'(res[5]), 256'(1));

    // Random neurons and vectors
    for (int i = 0; i < 6; i++) begin
      configNeuron(int'($urandom_range(8, NN - 1)), {$urandom, $urandom}, rand256());
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(rand256());
      waitResult(res);
    end

    // Backpressure with a second vector waiting
    m_ready = 1'b0;
    applyStimulus({rand256() >> 8, 8'h1F});
    waitValid();
    held = m_data;
    checkOutput("bp_maj_1F", 256'(held[5]), 256'(1));
    s_valid = 1'b1; s_data = rand256();
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp_m_valid", 256'(m_valid), 256'(1));
      checkOutput("bp_m_data", 256'(m_data), 256'(held));
      checkOutput("bp_s_ready", 256'(s_ready), 256'(0));
      tick();
    end
    m_ready = 1'b1;
    tick();
    checkOutput("bp_idle_busy", 256'(busy), 256'(0));
    checkOutput("bp_idle_s_ready", 256'(s_ready), 256'(1));
    tick();
    checkOutput("bp_second_accepted", 256'(busy), 256'(1));
    s_valid = 1'b0;
    waitResult(res);

    // Config write attempted during RUN must be ignored
    applyStimulus({rand256() >> 8, 8'h1F});
    cfg_we = 1'b1; cfg_nid = 7'd5; cfg_map = 64'h0706_0504_0302_0100; cfg_table = ~majTbl;
    for (int i = 0; i < 10; i++) begin
      checkOutput("run_cfg_ready", 256'(cfg_ready), 256'(0));
      tick();
    end
    cfg_we = 1'b0;
    waitResult(res);
    checkOutput("run_cfg_ignored", 256'(res[5]), 256'(1));

    // Out-of-range neuron id must not alias onto neuron 0
    configNeuron(NN, 64'h0, 256'h0);
    applyStimulus({rand256() >> 64, 64'h0123_4567_89AB_CDEF});
    waitResult(res);
    checkOutput("nid64_dropped", 256'(res[0]), 256'(1));

    // Same-cycle config write and vector accept
    cfg_we = 1'b1; cfg_nid = 7'd5; cfg_map = 64'h0706_0504_0302_0100; cfg_table = ~majTbl;
    s_valid = 1'b1; s_data = {rand256() >> 8, 8'h1F};
    tick();
    cfg_we = 1'b0; s_valid = 1'b0;
    waitResult(res);
    checkOutput("simul_new_table", 256'(res[5]), 256'(0));

    // Reset at neuron counter 30
    applyStimulus({rand256() >> 8, 8'h0F});
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("midrun_rst_busy", 256'(busy), 256'(0));
    for (int i = 0; i < 80; i++) begin
      checkOutput("midrun_no_valid", 256'(m_valid), 256'(0));
      tick();
    end
    applyStimulus({rand256() >> 8, 8'h0F});
    waitResult(res);
    checkOutput("after_rst_retained", 256'(res[5]), 256'(1));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
